sprite_compositor: RTL and testbench

- Parametrised N-channel sprite renderer; generalises the hard-wired single character/platform draw path into a reusable block.
- Per pixel: hit-tests every sprite, issues one sprite-sheet ROM address per channel, and aligns the returned ROM data to a fixed pipeline latency.
- Composites by priority with a transparency key over the background tile colour; output feeds pattern_gen.
- Owns per-sprite animation frame counters stepped by the VGA frame tick, replacing the counter-clocked animation FSM.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_compositor_if.sv | 12 +
 rtl/sprite_channel.sv | 82 ++++++++
 rtl/sprite_compositor.sv | 124 ++++++++++++
 tb/tb_sprite_compositor.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, sprite attribute bundle and sizing helpers for the sprite compositor.
package sprite_pkg;

    localparam logic [5:0] KEY_RGB = 6'b110011;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
        logic       mirror;
        logic       anim_en;
    } spr_attr_t;

    // Bits needed to hold a frame index 0..frames-1 (at least one).
    function automatic int frame_w(input int frames);
        int w;
        w = 1;
        for (int k = 1; k < 31; k++)
            if ((1 << w) < frames) w = k + 1;
        return w;
    endfunction

    // Flat index of the unordered channel pair (i<j) in the upper triangle.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * (n - 1) - (i * (i - 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Sprite-sheet ROM bus: one registered address out and one data word back per channel.
interface sprite_compositor_if #(
    parameter int NUM_SPR = 4,
    parameter int AW      = 14
);
    logic [NUM_SPR*AW-1:0] spr_addr;
    logic [NUM_SPR*6-1:0]  spr_rgb;

    // No handshake: the ROM accepts an address every cycle and returns its data a fixed latency later.
    modport master (output spr_addr, input spr_rgb);
    modport slave  (input spr_addr, output spr_rgb);
endinterface

// File: rtl/sprite_channel.sv
// One sprite channel: hit test, sheet address, hit delay line aligned to ROM data, animation counters.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int SPR_W    = 23,
    parameter int SPR_H    = 30,
    parameter int FRAMES_X = 3,
    parameter int FRAMES_Y = 2,
    parameter int SCALE_SH = 1,
    parameter int ROM_LAT  = 2,
    parameter int ANIM_DIV = 8,
    parameter int AW       = 14,
    localparam int FW      = frame_w(FRAMES_X * FRAMES_Y)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    col,
    input  logic [9:0]    row,
    input  logic          frame_tick,
    input  spr_attr_t     attr,
    output logic [AW-1:0] addr,
    output logic          hit_al,
    output logic [FW-1:0] frame
);

    localparam int FRAMES  = FRAMES_X * FRAMES_Y;
    localparam int SHEET_W = SPR_W * FRAMES_X;
    localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_SH);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_SH);
    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [10:0]      rel_x, rel_y;
    logic             hit;
    int               dx, dy, dxm, fc, fr;
    logic [AW-1:0]    addr_next;
    logic [ROM_LAT:0] hit_dly;
    logic [DIV_W-1:0] div_cnt;

    // 11-bit compare so boxes that run past the screen edge never wrap back to column/row 0.
    always_comb begin
        rel_x     = {1'b0, col} - {1'b0, attr.x};
        rel_y     = {1'b0, row} - {1'b0, attr.y};
        hit       = attr.en && (col >= attr.x) && (row >= attr.y) &&
                    (rel_x < BOX_W) && (rel_y < BOX_H);
        dx        = int'(rel_x >> SCALE_SH);
        dy        = int'(rel_y >> SCALE_SH);
        dxm       = attr.mirror ? (SPR_W - 1 - dx) : dx;
        fc        = int'(frame) % FRAMES_X;
        fr        = int'(frame) / FRAMES_X;
        addr_next = AW'((fr * SPR_H + dy) * SHEET_W + fc * SPR_W + dxm);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            hit_dly <= '0;
        end else begin
            addr       <= hit ? addr_next : '0;
            hit_dly[0] <= hit;
            for (int k = 1; k <= ROM_LAT; k++)
                hit_dly[k] <= hit_dly[k-1];
        end
    end

    assign hit_al = hit_dly[ROM_LAT];

    // Frame only ever moves on frame_tick, so a sprite never changes pose mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            frame   <= '0;
        end else if (frame_tick && attr.anim_en) begin
            if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt <= '0;
                frame   <= (frame == FW'(FRAMES - 1)) ? '0 : frame + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite renderer: per-channel ROM addressing, priority/transparency composite over bg_rgb.
// Optional pairwise collision flags when SPRITE_COLLIDE_EN is defined.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPR  = 4,
    parameter int SPR_W    = 23,
    parameter int SPR_H    = 30,
    parameter int FRAMES_X = 3,
    parameter int FRAMES_Y = 2,
    parameter int SCALE_SH = 1,
    parameter int ROM_LAT  = 2,
    parameter int ANIM_DIV = 8,
    parameter int AW       = 14,
    parameter logic [5:0] KEY = KEY_RGB,
    localparam int COLL_W  = (NUM_SPR * NUM_SPR / 2 < 1) ? 1 : NUM_SPR * NUM_SPR / 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             col,
    input  logic [9:0]             row,
    input  logic                   valid,
    input  logic                   frame_tick,
    input  logic [NUM_SPR*10-1:0]  spr_x,
    input  logic [NUM_SPR*10-1:0]  spr_y,
    input  logic [NUM_SPR-1:0]     spr_en,
    input  logic [NUM_SPR-1:0]     spr_mirror,
    input  logic [NUM_SPR-1:0]     spr_anim_en,
    sprite_compositor_if.master    rom,
    input  logic [5:0]             bg_rgb,
    output logic [5:0]             rgb_out,
    output logic                   rgb_valid,
    output logic [NUM_SPR*3-1:0]   spr_frame
`ifdef SPRITE_COLLIDE_EN
    ,
    output logic [COLL_W-1:0]      collide
`endif
);

    localparam int FW = frame_w(FRAMES_X * FRAMES_Y);

    logic [NUM_SPR-1:0] hit_al;
    logic [NUM_SPR-1:0] opaque;
    logic [FW-1:0]      frame_q [NUM_SPR];
    logic [ROM_LAT:0]   vld_dly;
    logic [5:0]         pix_next;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_chan
        spr_attr_t     attr;
        logic [AW-1:0] addr_q;

        assign attr.x       = spr_x[i*10 +: 10];
        assign attr.y       = spr_y[i*10 +: 10];
        assign attr.en      = spr_en[i];
        assign attr.mirror  = spr_mirror[i];
        assign attr.anim_en = spr_anim_en[i];

        sprite_channel #(
            .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES_X(FRAMES_X), .FRAMES_Y(FRAMES_Y),
            .SCALE_SH(SCALE_SH), .ROM_LAT(ROM_LAT), .ANIM_DIV(ANIM_DIV), .AW(AW)
        ) u_chan (
            .clk(clk), .rst_n(rst_n), .col(col), .row(row), .frame_tick(frame_tick),
            .attr(attr), .addr(addr_q), .hit_al(hit_al[i]), .frame(frame_q[i])
        );

        assign rom.spr_addr[i*AW +: AW] = addr_q;
        assign spr_frame[i*3 +: 3]      = 3'(frame_q[i]);
        assign opaque[i] = hit_al[i] && (rom.spr_rgb[i*6 +: 6] != KEY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_dly <= '0;
        end else begin
            vld_dly[0] <= valid;
            for (int k = 1; k <= ROM_LAT; k++)
                vld_dly[k] <= vld_dly[k-1];
        end
    end

    // Walk from lowest priority up so channel 0 has the last word.
    always_comb begin
        pix_next = bg_rgb;
        for (int i = NUM_SPR - 1; i >= 0; i--)
            if (opaque[i]) pix_next = rom.spr_rgb[i*6 +: 6];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_out   <= vld_dly[ROM_LAT] ? pix_next : 6'd0;
            rgb_valid <= vld_dly[ROM_LAT];
        end
    end

`ifdef SPRITE_COLLIDE_EN
    logic [COLL_W-1:0] pair_now;
    logic [COLL_W-1:0] coll_work;

    always_comb begin
        pair_now = '0;
        for (int i = 0; i < NUM_SPR; i++)
            for (int j = i + 1; j < NUM_SPR; j++)
                if (vld_dly[ROM_LAT] && opaque[i] && opaque[j])
                    pair_now[pair_idx(i, j, NUM_SPR)] = 1'b1;
    end

    // Working flags accumulate over a frame and are published/cleared together on frame_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_work <= '0;
            collide   <= '0;
        end else if (frame_tick) begin
            collide   <= coll_work | pair_now;
            coll_work <= '0;
        end else begin
            coll_work <= coll_work | pair_now;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: constant vector table, latency/animation/reset sequences, random vs. model.
module tb_sprite_compositor;

    localparam int N = 4;
    localparam int AW = 14;
    localparam int SPR_W = 23;
    localparam int SPR_H = 30;
    localparam int FRAMES_X = 3;
    localparam int FRAMES = 6;
    localparam int SCALE = 2;
    localparam int ANIM_DIV = 8;
    localparam logic [5:0] KEY = 6'b110011;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [9:0]     col = '0, row = '0;
    logic           valid = 1'b0, frame_tick = 1'b0;
    logic [N*10-1:0] spr_x = '0, spr_y = '0;
    logic [N-1:0]   spr_en = '0, spr_mirror = '0, spr_anim_en = '0;
    logic [5:0]     bg_rgb = '0;
    logic [5:0]     rgb_out;
    logic           rgb_valid;
    logic [N*3-1:0] spr_frame;

    sprite_compositor_if #(.NUM_SPR(N), .AW(AW)) rom_if ();

    sprite_compositor dut (
        .clk(clk), .rst_n(rst_n), .col(col), .row(row), .valid(valid),
        .frame_tick(frame_tick), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
        .spr_mirror(spr_mirror), .spr_anim_en(spr_anim_en), .rom(rom_if),
        .bg_rgb(bg_rgb), .rgb_out(rgb_out), .rgb_valid(rgb_valid), .spr_frame(spr_frame)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        int         x0, y0, x1, y1;
        logic [3:0] en, mir;
        int         col, row;
        bit         vld;
        logic [5:0] rom0, rom1, bg;
        int         exp_a0, exp_a1;
        logic [5:0] exp_rgb;
        bit         exp_v;
    } vec_t;

    typedef struct {
        int         col, row;
        bit         vld;
        int         x[N];
        int         y[N];
        bit         en[N];
        bit         mir[N];
        logic [5:0] rom[N];
        logic [5:0] bg;
    } rec_t;

    vec_t tbl[$];
    rec_t hist[$];
    logic [6:0]      exp_q[$];
    logic [N*AW-1:0] exp_addr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_spr(input int i, input int x, input int y, input bit en, input bit mir);
        spr_x[i*10 +: 10] = 10'(x);
        spr_y[i*10 +: 10] = 10'(y);
        spr_en[i]         = en;
        spr_mirror[i]     = mir;
    endtask

    task automatic set_rom(input int i, input logic [5:0] v);
        rom_if.spr_rgb[i*6 +: 6] = v;
    endtask

    // Reference model straight from the geometric rules of the sheet layout.
    function automatic bit model_hit(input int c, input int r, input int x, input int y, input bit en);
        return en && c >= x && c < x + SPR_W * SCALE && r >= y && r < y + SPR_H * SCALE;
    endfunction

    function automatic int model_addr(input int c, input int r, input int x, input int y,
                                      input bit mir, input int f);
        int dx, dy;
        dx = (c - x) / SCALE;
        dy = (r - y) / SCALE;
        if (mir) dx = SPR_W - 1 - dx;
        return ((f / FRAMES_X) * SPR_H + dy) * (SPR_W * FRAMES_X) + (f % FRAMES_X) * SPR_W + dx;
    endfunction

    task automatic add_vec(input string name, input int x0, y0, x1, y1, input logic [3:0] en, mir,
                           input int c, r, input bit vld, input logic [5:0] rom0, rom1, bg,
                           input int a0, a1, input logic [5:0] ergb, input bit ev);
        vec_t v;
        v.name = name; v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.en = en; v.mir = mir;
        v.col = c; v.row = r; v.vld = vld; v.rom0 = rom0; v.rom1 = rom1; v.bg = bg;
        v.exp_a0 = a0; v.exp_a1 = a1; v.exp_rgb = ergb; v.exp_v = ev;
        tbl.push_back(v);
    endtask

    initial begin
        int en_ticks;
        rom_if.spr_rgb = {N{KEY}};

        // Reset state
        do_reset();
        check("reset_rgb", rgb_out, 0);
        check("reset_valid", rgb_valid, 0);
        check("reset_frame", spr_frame, 0);
        check("reset_addr", rom_if.spr_addr, 0);

        // Steady-state vector table
        add_vec("addr_origin", 100, 50, 400, 400, 4'b0001, 4'b0000, 101, 51, 1, 6'h0A, 6'h0B, 6'h07, 0, 0, 6'h0A, 1);
        add_vec("addr_step",   100, 50, 400, 400, 4'b0001, 4'b0000, 102, 52, 1, KEY,   6'h0B, 6'h07, 70, 0, 6'h07, 1);
        add_vec("mirror_key",  100, 50, 400, 400, 4'b0001, 4'b0001, 102, 52, 1, KEY,   6'h0B, 6'h07, 90, 0, 6'h07, 1);
        add_vec("left_miss",   100, 50, 400, 400, 4'b0001, 4'b0000, 99, 51, 1, 6'h0A, 6'h0B, 6'h07, 0, 0, 6'h07, 1);
        add_vec("last_px",     100, 50, 400, 400, 4'b0001, 4'b0000, 145, 109, 1, 6'h01, 6'h0B, 6'h07, 2023, 0, 6'h01, 1);
        add_vec("right_miss",  100, 50, 400, 400, 4'b0001, 4'b0000, 146, 109, 1, 6'h01, 6'h0B, 6'h07, 0, 0, 6'h07, 1);
        add_vec("bottom_miss", 100, 50, 400, 400, 4'b0001, 4'b0000, 145, 110, 1, 6'h01, 6'h0B, 6'h07, 0, 0, 6'h07, 1);
        add_vec("prio",        200, 200, 190, 190, 4'b0011, 4'b0000, 200, 200, 1, 6'h0A, 6'h15, 6'h07, 0, 350, 6'h0A, 1);
        add_vec("prio_key",    200, 200, 190, 190, 4'b0011, 4'b0000, 200, 200, 1, KEY,   6'h15, 6'h07, 0, 350, 6'h15, 1);
        add_vec("both_key",    200, 200, 190, 190, 4'b0011, 4'b0000, 200, 200, 1, KEY,   KEY,   6'h07, 0, 350, 6'h07, 1);
        add_vec("blank",       100, 50, 400, 400, 4'b0001, 4'b0000, 102, 52, 0, 6'h0A, 6'h0B, 6'h07, 70, 0, 6'h00, 0);
        add_vec("disabled",    100, 50, 400, 400, 4'b0000, 4'b0000, 101, 51, 1, 6'h0A, 6'h0B, 6'h07, 0, 0, 6'h07, 1);
        add_vec("right_edge",  620, 100, 400, 400, 4'b0001, 4'b0000, 639, 100, 1, 6'h2A, 6'h0B, 6'h07, 9, 0, 6'h2A, 1);
        add_vec("no_wrap",     620, 100, 400, 400, 4'b0001, 4'b0000, 0, 101, 1, 6'h2A, 6'h0B, 6'h07, 0, 0, 6'h07, 1);

        for (int v = 0; v < tbl.size(); v++) begin
            set_spr(0, tbl[v].x0, tbl[v].y0, tbl[v].en[0], tbl[v].mir[0]);
            set_spr(1, tbl[v].x1, tbl[v].y1, tbl[v].en[1], tbl[v].mir[1]);
            set_spr(2, 0, 0, 1'b0, 1'b0);
            set_spr(3, 0, 0, 1'b0, 1'b0);
            col = 10'(tbl[v].col); row = 10'(tbl[v].row); valid = tbl[v].vld;
            set_rom(0, tbl[v].rom0); set_rom(1, tbl[v].rom1); bg_rgb = tbl[v].bg;
            repeat (6) tick();
            check({tbl[v].name, "_addr0"}, rom_if.spr_addr[0 +: AW], tbl[v].exp_a0);
            check({tbl[v].name, "_addr1"}, rom_if.spr_addr[AW +: AW], tbl[v].exp_a1);
            check({tbl[v].name, "_rgb"}, rgb_out, tbl[v].exp_rgb);
            check({tbl[v].name, "_valid"}, rgb_valid, tbl[v].exp_v);
        end

        // Latency: one valid pixel, address one edge later, composite four edges later
        set_spr(0, 100, 50, 1'b1, 1'b0); set_spr(1, 0, 0, 1'b0, 1'b0);
        col = 0; row = 0; valid = 1'b0; set_rom(0, 6'h0A); bg_rgb = 6'h07;
        repeat (6) tick();
        col = 102; row = 52; valid = 1'b1;
        tick();
        check("lat_addr_t1", rom_if.spr_addr[0 +: AW], 70);
        col = 0; row = 0; valid = 1'b0;
        tick();
        check("lat_addr_t2", rom_if.spr_addr[0 +: AW], 0);
        tick();
        check("lat_valid_t3", rgb_valid, 0);
        tick();
        check("lat_valid_t4", rgb_valid, 1);
        check("lat_rgb_t4", rgb_out, 6'h0A);
        tick();
        check("lat_valid_t5", rgb_valid, 0);

        // Animation: 48 ticks walk frames 0..5 and back to 0
        do_reset();
        spr_anim_en = 4'b0001;
        col = 100; row = 50; valid = 1'b1;
        en_ticks = 0;
        for (int tk = 1; tk <= 48; tk++) begin
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; en_ticks++;
            check("anim_frame0", spr_frame[2:0], (en_ticks / ANIM_DIV) % FRAMES);
            check("anim_frame1", spr_frame[5:3], 0);
            tick();
            if (tk == 32)
                check("anim_addr_f4", rom_if.spr_addr[0 +: AW], model_addr(100, 50, 100, 50, 0, 4));
        end
        check("anim_wrap", spr_frame[2:0], 0);
        repeat (4) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick(); en_ticks++;
        end
        spr_anim_en = 4'b0000;
        repeat (20) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
        end
        check("freeze_frame", spr_frame[2:0], (en_ticks / ANIM_DIV) % FRAMES);
        spr_anim_en = 4'b0001;
        repeat (4) begin
            frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick(); en_ticks++;
        end
        check("resume_frame", spr_frame[2:0], (en_ticks / ANIM_DIV) % FRAMES);

        // Asynchronous reset in the middle of a line
        set_rom(0, 6'h0A);
        repeat (6) tick();
        check("pre_rst_rgb", rgb_out, 6'h0A);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", rgb_out, 0);
        check("async_rst_valid", rgb_valid, 0);
        check("async_rst_frame", spr_frame, 0);
        check("async_rst_addr", rom_if.spr_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        spr_anim_en = '0;
        #1;

        // Random stimulus against the reference model, cycle-exact pipeline timing
        for (int c = 0; c < 400; c++) begin
            rec_t r;
            rec_t iss;
            logic [N*AW-1:0] ea;
            logic [5:0] pix;
            if (exp_addr_q.size() > 0) check("rand_addr", rom_if.spr_addr, exp_addr_q.pop_front());
            if (exp_q.size() > 0) check("rand_pix", {rgb_valid, rgb_out}, exp_q.pop_front());

            r.col = $urandom_range(0, 180); r.row = $urandom_range(0, 200);
            r.vld = ($urandom_range(0, 3) != 0);
            r.bg  = 6'($urandom_range(0, 63));
            for (int i = 0; i < N; i++) begin
                r.x[i] = $urandom_range(0, 120); r.y[i] = $urandom_range(0, 120);
                r.en[i] = ($urandom_range(0, 4) != 0); r.mir[i] = 1'($urandom_range(0, 1));
                r.rom[i] = ($urandom_range(0, 2) == 0) ? KEY : 6'($urandom_range(0, 63));
                set_spr(i, r.x[i], r.y[i], r.en[i], r.mir[i]);
                set_rom(i, r.rom[i]);
            end
            col = 10'(r.col); row = 10'(r.row); valid = r.vld; bg_rgb = r.bg;
            hist.push_back(r);

            for (int i = 0; i < N; i++)
                ea[i*AW +: AW] = model_hit(r.col, r.row, r.x[i], r.y[i], r.en[i]) ?
                                 AW'(model_addr(r.col, r.row, r.x[i], r.y[i], r.mir[i], 0)) : '0;
            exp_addr_q.push_back(ea);

            if (hist.size() >= 4) begin
                iss = hist[hist.size() - 4];
                pix = r.bg;
                for (int i = N - 1; i >= 0; i--)
                    if (model_hit(iss.col, iss.row, iss.x[i], iss.y[i], iss.en[i]) && r.rom[i] != KEY)
                        pix = r.rom[i];
                exp_q.push_back(iss.vld ? {1'b1, pix} : 7'd0);
                void'(hist.pop_front());
            end
            tick();
        end
        if (exp_addr_q.size() > 0) check("rand_addr", rom_if.spr_addr, exp_addr_q.pop_front());
        if (exp_q.size() > 0) check("rand_pix", {rgb_valid, rgb_out}, exp_q.pop_front());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
